// File: rtl/code_entry_checker.sv
// code_entry_checker
// Assembles keypad digits from the upstream input_encoder into a DIGITS-long
// code word, checks it on enter, and drives unlock / error / lockout status
// with a retry counter and a timed lockout after MAX_TRIES failures.
//
// Optional feature macro: CODE_PROG_EN
//   defined   : code held in a register, reprogrammable from OPEN
//   undefined : code is the constant DEFAULT_CODE, prog_ok tied low
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   key_valid  in   encoder valid level (held while the key is down)
//   key_code   in   encoder BCD: 0-9 digit, A clear, B enter, C-F ignored
//   unlocked   out  high while in OPEN
//   err        out  one-cycle pulse on a failed check
//   locked_out out  high while in LOCKOUT
//   entry_cnt  out  digits currently buffered
//   tries      out  consecutive failed checks
//   prog_ok    out  one-cycle pulse when the code is reprogrammed
module code_entry_checker #(
    parameter int unsigned          DIGITS       = 6,
    parameter int unsigned          MAX_TRIES    = 3,
    parameter int unsigned          OPEN_CYCLES  = 50,
    parameter int unsigned          LOCK_CYCLES  = 100,
    parameter logic [4*DIGITS-1:0]  DEFAULT_CODE = 24'h219354
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       unlocked,
    output logic       err,
    output logic       locked_out,
    output logic [2:0] entry_cnt,
    output logic [1:0] tries,
    output logic       prog_ok
);

    localparam int unsigned BW   = 4 * DIGITS;
    localparam int unsigned TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ENTRY   = 3'd1;
    localparam logic [2:0] S_CHECK   = 3'd2;
    localparam logic [2:0] S_OPEN    = 3'd3;
    localparam logic [2:0] S_FAIL    = 3'd4;
    localparam logic [2:0] S_LOCKOUT = 3'd5;

    localparam logic [2:0]    CNT_FULL  = 3'(DIGITS);
    localparam logic [TW-1:0] OPEN_LAST = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_CYCLES - 1);

    logic [2:0]    state_q, state_d;
    logic          prev_q;
    logic [BW-1:0] buf_q, buf_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [1:0]    tries_q, tries_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [BW-1:0] code_c;
    logic          prog_d;

    logic          press_c;
    logic          dig_c;
    logic          clr_c;
    logic          ent_c;
    logic          full_c;
    logic          match_c;
    logic          last_try_c;
    logic [BW-1:0] shift_c;

    // Single event per press: rising edge of the held valid level.
    assign press_c = key_valid & ~prev_q;
    assign dig_c   = press_c && (key_code <= 4'd9);
    assign clr_c   = press_c && (key_code == 4'hA);
    assign ent_c   = press_c && (key_code == 4'hB);

    assign full_c     = (cnt_q == CNT_FULL);
    assign shift_c    = (buf_q << 4) | BW'(key_code);
    assign match_c    = full_c && (buf_q == code_c);
    assign last_try_c = ((32'(tries_q) + 32'd1) == MAX_TRIES);

`ifdef CODE_PROG_EN
    logic [BW-1:0] code_q, code_d;
    assign code_c = code_q;
`else
    assign code_c = DEFAULT_CODE;
`endif

    // Next-state, buffer, retry and timer logic.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        tries_d = tries_q;
        timer_d = timer_q;
        prog_d  = 1'b0;
`ifdef CODE_PROG_EN
        code_d  = code_q;
`endif
        case (state_q)
            S_IDLE: begin
                buf_d = '0;
                cnt_d = 3'd0;
                if (dig_c) begin
                    state_d = S_ENTRY;
                    buf_d   = BW'(key_code);
                    cnt_d   = 3'd1;
                end
            end
            S_ENTRY: begin
                if (clr_c) begin
                    state_d = S_IDLE;
                    buf_d   = '0;
                    cnt_d   = 3'd0;
                end else if (ent_c) begin
                    state_d = S_CHECK;
                end else if (dig_c && !full_c) begin
                    buf_d = shift_c;
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_CHECK: begin
                buf_d   = '0;
                cnt_d   = 3'd0;
                timer_d = '0;
                if (match_c) begin
                    state_d = S_OPEN;
                    tries_d = 2'd0;
                end else if (last_try_c) begin
                    // tries holds at MAX_TRIES-1 until lockout expires
                    state_d = S_LOCKOUT;
                end else begin
                    state_d = S_FAIL;
                    tries_d = tries_q + 2'd1;
                end
            end
            S_FAIL: begin
                state_d = S_IDLE;
            end
            S_OPEN: begin
`ifdef CODE_PROG_EN
                if (ent_c && full_c) begin
                    state_d = S_IDLE;
                    code_d  = buf_q;
                    prog_d  = 1'b1;
                    buf_d   = '0;
                    cnt_d   = 3'd0;
                end else
`endif
                if (clr_c || (timer_q == OPEN_LAST)) begin
                    state_d = S_IDLE;
                    buf_d   = '0;
                    cnt_d   = 3'd0;
                end else begin
                    timer_d = timer_q + TW'(1);
                    if (dig_c && !full_c) begin
                        buf_d = shift_c;
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            S_LOCKOUT: begin
                if (timer_q == LOCK_LAST) begin
                    state_d = S_IDLE;
                    tries_d = 2'd0;
                    buf_d   = '0;
                    cnt_d   = 3'd0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                buf_d   = '0;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // State and datapath registers; status outputs track the next state so
    // they line up exactly with the registered state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            prev_q     <= 1'b0;
            buf_q      <= '0;
            cnt_q      <= 3'd0;
            tries_q    <= 2'd0;
            timer_q    <= '0;
            unlocked   <= 1'b0;
            err        <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= key_valid;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            tries_q    <= tries_d;
            timer_q    <= timer_d;
            unlocked   <= (state_d == S_OPEN);
            err        <= (state_d == S_FAIL);
            locked_out <= (state_d == S_LOCKOUT);
        end
    end

`ifdef CODE_PROG_EN
    // Programmable code register; only rst restores the default.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q  <= DEFAULT_CODE;
            prog_ok <= 1'b0;
        end else begin
            code_q  <= code_d;
            prog_ok <= prog_d;
        end
    end
`else
    assign prog_ok = 1'b0;
    logic unused_prog;
    assign unused_prog = prog_d;
`endif

    assign entry_cnt = cnt_q;
    assign tries     = tries_q;

endmodule

// File: tb/tb_code_entry_checker.sv
// Directed testbench for code_entry_checker (default parameters).
// Follows the CODE_PROG_EN macro to choose the expected programming behaviour.
module tb_code_entry_checker;

    logic       clk;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic       unlocked;
    logic       err;
    logic       locked_out;
    logic [2:0] entry_cnt;
    logic [1:0] tries;
    logic       prog_ok;

    int total = 0;
    int bad   = 0;

    code_entry_checker dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .unlocked  (unlocked),
        .err       (err),
        .locked_out(locked_out),
        .entry_cnt (entry_cnt),
        .tries     (tries),
        .prog_ok   (prog_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k, input int hold, input int gap);
        key_code  = k;
        key_valid = 1'b1;
        repeat (hold) tick();
        key_valid = 1'b0;
        repeat (gap) tick();
    endtask

    // Enter press sampled at the first edge; status is valid after the second.
    task automatic enter_key();
        key_code  = 4'hB;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        tick();
    endtask

    task automatic type_code(input logic [23:0] c, input int hold, input int gap);
        for (int i = 0; i < 6; i++) begin
            press(c[4*(5-i) +: 4], hold, gap);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; key_valid = 1'b0; key_code = 4'h0;
        repeat (3) tick();
        total++; if ({unlocked, err, locked_out, prog_ok} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", {unlocked, err, locked_out, prog_ok}); end
        total++; if (entry_cnt !== 3'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", entry_cnt); end
        total++; if (tries !== 2'd0) begin bad++; $display("FAIL reset_tries: got %0d want 0", tries); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unlock();
        logic [23:0] c;
        int n;
        c = 24'h219354;
        for (int i = 0; i < 6; i++) begin
            press(c[4*(5-i) +: 4], 5, 5);
            total++; if (entry_cnt !== 3'(i + 1)) begin bad++; $display("FAIL unlock_cnt%0d: got %0d want %0d", i, entry_cnt, i + 1); end
        end
        enter_key();
        total++; if (unlocked !== 1'b1) begin bad++; $display("FAIL unlock_hi: got %b want 1", unlocked); end
        total++; if (tries !== 2'd0) begin bad++; $display("FAIL unlock_tries: got %0d want 0", tries); end
        n = 0;
        while (unlocked === 1'b1 && n < 200) begin n++; tick(); end
        total++; if (n != 50) begin bad++; $display("FAIL unlock_len: got %0d want 50", n); end
        total++; if (entry_cnt !== 3'd0) begin bad++; $display("FAIL unlock_exit_cnt: got %0d want 0", entry_cnt); end
    endtask

    task automatic test_fail_lockout();
        int n;
        int leaks;
        for (int r = 0; r < 3; r++) begin
            type_code(24'h219355, 2, 2);
            enter_key();
            if (r < 2) begin
                total++; if (err !== 1'b1) begin bad++; $display("FAIL fail%0d_err: got %b want 1", r, err); end
                total++; if (tries !== 2'(r + 1)) begin bad++; $display("FAIL fail%0d_tries: got %0d want %0d", r, tries, r + 1); end
                tick();
                total++; if (err !== 1'b0) begin bad++; $display("FAIL fail%0d_pulse: got %b want 0", r, err); end
                total++; if (entry_cnt !== 3'd0) begin bad++; $display("FAIL fail%0d_cnt: got %0d want 0", r, entry_cnt); end
            end else begin
                total++; if ({locked_out, err} !== 2'b10) begin bad++; $display("FAIL lock_enter: got %b want 10", {locked_out, err}); end
                total++; if (tries !== 2'd2) begin bad++; $display("FAIL lock_tries_hold: got %0d want 2", tries); end
            end
        end
        n = 0; leaks = 0;
        while (locked_out === 1'b1 && n < 300) begin
            if (entry_cnt !== 3'd0 || unlocked !== 1'b0) leaks++;
            key_code  = 4'd2;
            key_valid = (n % 3 == 0);
            n++;
            tick();
        end
        key_valid = 1'b0;
        total++; if (n != 100) begin bad++; $display("FAIL lock_len: got %0d want 100", n); end
        total++; if (leaks != 0) begin bad++; $display("FAIL lock_keys: got %0d leaks want 0", leaks); end
        tick();
        total++; if (tries !== 2'd0) begin bad++; $display("FAIL lock_exit_tries: got %0d want 0", tries); end
        total++; if (entry_cnt !== 3'd0) begin bad++; $display("FAIL lock_exit_cnt: got %0d want 0", entry_cnt); end
    endtask

    task automatic test_hold_overflow();
        press(4'd7, 20, 2);
        total++; if (entry_cnt !== 3'd1) begin bad++; $display("FAIL hold_cnt: got %0d want 1", entry_cnt); end
        press(4'hA, 1, 1);
        total++; if (entry_cnt !== 3'd0) begin bad++; $display("FAIL hold_clear: got %0d want 0", entry_cnt); end
        for (int i = 1; i <= 7; i++) press(4'(i), 2, 2);
        total++; if (entry_cnt !== 3'd6) begin bad++; $display("FAIL ovf_cnt: got %0d want 6", entry_cnt); end
        enter_key();
        total++; if ({err, unlocked} !== 2'b10) begin bad++; $display("FAIL ovf_err: got %b want 10", {err, unlocked}); end
        total++; if (tries !== 2'd1) begin bad++; $display("FAIL ovf_tries: got %0d want 1", tries); end
        tick();
        // seventh digit dropped: 2,1,9,3,5,4,7 still matches
        type_code(24'h219354, 2, 2);
        press(4'd7, 2, 2);
        enter_key();
        total++; if (unlocked !== 1'b1) begin bad++; $display("FAIL ovf_unlock: got %b want 1", unlocked); end
        total++; if (tries !== 2'd0) begin bad++; $display("FAIL ovf_tries_clr: got %0d want 0", tries); end
        press(4'hA, 1, 0);
        total++; if (unlocked !== 1'b0) begin bad++; $display("FAIL open_clear: got %b want 0", unlocked); end
        tick();
    endtask

    task automatic test_clear();
        press(4'd2, 2, 2); press(4'd1, 2, 2); press(4'd9, 2, 2);
        total++; if (entry_cnt !== 3'd3) begin bad++; $display("FAIL clr_pre: got %0d want 3", entry_cnt); end
        press(4'hA, 2, 2);
        total++; if (entry_cnt !== 3'd0) begin bad++; $display("FAIL clr_cnt: got %0d want 0", entry_cnt); end
        total++; if ({err, unlocked, locked_out} !== 3'b000) begin bad++; $display("FAIL clr_flags: got %b want 000", {err, unlocked, locked_out}); end
        enter_key();
        total++; if ({err, unlocked, entry_cnt} !== 5'b0) begin bad++; $display("FAIL idle_enter: got %b want 0", {err, unlocked, entry_cnt}); end
    endtask

    task automatic test_reset_mid_open();
        type_code(24'h219354, 2, 2);
        enter_key();
        repeat (5) tick();
        press(4'd8, 2, 2);
        total++; if ({unlocked, entry_cnt} !== 4'b1001) begin bad++; $display("FAIL open_digit: got %b want 1001", {unlocked, entry_cnt}); end
        key_code = 4'd5; key_valid = 1'b1; rst = 1'b1;
        tick();
        total++; if ({unlocked, err, locked_out, prog_ok, entry_cnt, tries} !== 9'b0) begin bad++; $display("FAIL rst_open: got %b want 0", {unlocked, err, locked_out, prog_ok, entry_cnt, tries}); end
        rst = 1'b0;
        tick();
        total++; if (entry_cnt !== 3'd1) begin bad++; $display("FAIL rst_held_key: got %0d want 1", entry_cnt); end
        key_valid = 1'b0;
        tick();
        press(4'hA, 1, 1);
    endtask

    task automatic test_prog();
        type_code(24'h219354, 2, 2);
        enter_key();
        total++; if (unlocked !== 1'b1) begin bad++; $display("FAIL prog_unlock: got %b want 1", unlocked); end
        type_code(24'h111111, 2, 2);
        key_code = 4'hB; key_valid = 1'b1;
        tick();
`ifdef CODE_PROG_EN
        total++; if ({prog_ok, unlocked} !== 2'b10) begin bad++; $display("FAIL prog_pulse: got %b want 10", {prog_ok, unlocked}); end
        key_valid = 1'b0;
        tick();
        total++; if (prog_ok !== 1'b0) begin bad++; $display("FAIL prog_pulse_end: got %b want 0", prog_ok); end
        type_code(24'h111111, 2, 2);
        enter_key();
        total++; if (unlocked !== 1'b1) begin bad++; $display("FAIL prog_new_code: got %b want 1", unlocked); end
        press(4'hA, 1, 1);
        type_code(24'h219354, 2, 2);
        enter_key();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL prog_old_code: got %b want 1", err); end
        tick();
`else
        total++; if ({prog_ok, unlocked} !== 2'b01) begin bad++; $display("FAIL noprog_enter: got %b want 01", {prog_ok, unlocked}); end
        key_valid = 1'b0;
        tick();
        press(4'hA, 1, 1);
        type_code(24'h111111, 2, 2);
        enter_key();
        total++; if ({err, unlocked} !== 2'b10) begin bad++; $display("FAIL noprog_new_code: got %b want 10", {err, unlocked}); end
        tick();
        type_code(24'h219354, 2, 2);
        enter_key();
        total++; if ({unlocked, prog_ok} !== 2'b10) begin bad++; $display("FAIL noprog_old_code: got %b want 10", {unlocked, prog_ok}); end
        press(4'hA, 1, 1);
`endif
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_fail_lockout();
        test_hold_overflow();
        test_clear();
        test_reset_mid_open();
        test_prog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/code_entry_checker.md
# code_entry_checker

Digit-sequence checker that sits directly downstream of the keypad `input_encoder`. It consumes the encoder's valid flag and BCD code, and assembles key presses into a `DIGITS`-long code word. On an enter key it compares the word against the stored access code and drives unlock, error and lockout outputs, with a retry counter and a timed lockout after repeated failures.

## Interface
- `DIGITS`, 6: code length in digits; 1–7.
- `MAX_TRIES`, 3: consecutive failed checks that trigger lockout; ≥1.
- `OPEN_CYCLES`, 50: cycles `unlocked` stays high.
- `LOCK_CYCLES`, 100: cycles spent in lockout.
- `DEFAULT_CODE`, 24'h219354: reset-time access code, `4*DIGITS` bits.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `key_valid`  in  1: encoder valid flag (`out[4]`), level, held while the key is held.
- `key_code`  in  4: encoder BCD (`out[3:0]`); 0–9 digit, 4'hA clear, 4'hB enter, 12–15 ignored.
- `unlocked`  out  1: high in OPEN.
- `err`  out  1: one-cycle pulse on a failed check.
- `locked_out`  out  1: high in LOCKOUT.
- `entry_cnt`  out  3: digits currently buffered.
- `tries`  out  2: consecutive failed checks so far.
- `prog_ok`  out  1: one-cycle pulse when the code is reprogrammed (only with `CODE_PROG_EN`).

## Operation
- Press event: `key_valid`=1 while the registered previous `key_valid`=0. Exactly one event per press regardless of hold length. A held key never repeats.
- Buffer: `4*DIGITS` bits. A digit press shifts the buffer left by one nibble and loads the new digit into the low nibble, so the first digit ends up most significant. `entry_cnt` saturates at `DIGITS`; further digits are dropped and the buffer is unchanged.
- States: IDLE, ENTRY, CHECK, OPEN, FAIL, LOCKOUT.
  - **IDLE:** buffer=0, `entry_cnt`=0. A digit moves to ENTRY (digit stored). Enter and clear are ignored.
  - **ENTRY:**
    - Digit: stored.
    - Clear: go to IDLE.
    - Enter: go to CHECK.
  - **CHECK** (1 cycle):
    - Match requires `entry_cnt`==`DIGITS` and buffer==code.
    - Match: go to OPEN, `tries`←0.
    - Mismatch with `tries`+1==`MAX_TRIES`: go to LOCKOUT.
    - Other mismatch: `tries`+1, go to FAIL.
  - **FAIL** (1 cycle): `err`=1, then IDLE.
  - **OPEN:** `unlocked`=1. Returns to IDLE after `OPEN_CYCLES` cycles, or earlier on clear. Digit presses are buffered (entry counter active) for programming.
  - **LOCKOUT:** all keys ignored. After `LOCK_CYCLES` cycles go to IDLE with `tries`←0.
- Leaving CHECK, OPEN or LOCKOUT clears the buffer and `entry_cnt`.
- Keys presented in CHECK or FAIL are discarded. The edge register still tracks them, so they do not fire later.
- `tries` is a 2-bit register that never exceeds `MAX_TRIES`-1.

## Timing
- Reset (`rst`=1 at an edge) puts the block in IDLE with:
  - buffer=0, `entry_cnt`=0, `tries`=0.
  - code=`DEFAULT_CODE`.
  - `unlocked`=`err`=`locked_out`=`prog_ok`=0.
  - previous-valid register=0.
- Reset wins over every event, including mid-OPEN or mid-LOCKOUT. A key held through reset release registers as a press on the first edge after release.
- A press sampled at edge N is visible in `entry_cnt` and state after edge N.
- Enter sampled at edge N: CHECK after N. `unlocked`/`err`/`locked_out` are asserted after N+1.
- OPEN and LOCKOUT durations count from the first cycle in the state. Exactly `OPEN_CYCLES` / `LOCK_CYCLES` cycles, then IDLE.
- Simultaneous timeout and clear in OPEN: go to IDLE (same result).
- All outputs are registered or decoded from the state register; no combinational input-to-output path.

## Configuration
- `CODE_PROG_EN` defined:
  - In OPEN, an enter press with `entry_cnt`==`DIGITS` loads the buffer into the code register, pulses `prog_ok` for one cycle and goes to IDLE.
  - An enter press with fewer digits is ignored.
  - The code register survives everything except `rst`.
- `CODE_PROG_EN` undefined:
  - The code is the constant `DEFAULT_CODE` and no code register is built.
  - Enter in OPEN is ignored.
  - `prog_ok` is tied to 0.

## Test plan
- Keys 2,1,9,3,5,4 then 4'hB, each held 5 cycles with 5-cycle gaps -> `entry_cnt` 1..6, `unlocked`=1 for exactly 50 cycles, `tries`=0.
- Keys 2,1,9,3,5,5,B -> `err` single pulse, `tries`=1, state IDLE. Repeat twice more -> second failure `tries`=2; third -> `locked_out`=1 for 100 cycles, keys ignored, then `tries`=0.
- Key 7 held 20 cycles -> `entry_cnt`=1 only. Seven digits 1..7 then B -> buffer 24'h123456, mismatch -> `err`.
- Keys 2,1,9 then 4'hA -> `entry_cnt`=0, IDLE, no `err`. Then `rst` asserted mid-OPEN -> all outputs 0 on the next edge.
- With `CODE_PROG_EN`: unlock, then enter 1,1,1,1,1,1,B -> `prog_ok` pulse. Then 1,1,1,1,1,1,B unlocks and 2,1,9,3,5,4,B raises `err`.
- Without `CODE_PROG_EN`: the same sequence gives no `prog_ok`, and 2,1,9,3,5,4 still unlocks.
